// File: rtl/matrix_operand_loader_pkg.sv
// Constants shared by the Kalman matrix datapath stages.
package matrix_operand_loader_pkg;
  localparam int COEF_W    = 32;
  localparam int COEF_Q    = 18;
  localparam int MAT_P     = 4;
  localparam int MAT_SLOTS = MAT_P * MAT_P;
  localparam int FRAME_LEN = 2 * MAT_SLOTS;
endpackage

// File: rtl/matrix_slot_writer.sv
// P*P coefficient register bank, one slot written per cycle
// through a one-hot enable.
module matrix_slot_writer
  import matrix_operand_loader_pkg::*;
#(
  parameter int N     = COEF_W,
  parameter int SLOTS = MAT_SLOTS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SLOTS-1:0]   we,
  input  logic [N-1:0]       data,
  output logic [SLOTS*N-1:0] bus
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (we[i]) bus[i*N +: N] <= data;
      end
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial coefficient loader for the Kalman 4x4 matrix multiplier.
// Assembles A then B from a word stream and presents both as one frame.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
#(
  parameter int N = COEF_W,
  parameter int P = MAT_P
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [P*P*N-1:0]     a_out,
  output logic [P*P*N-1:0]     b_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err
);

  localparam int SLOTS = P * P;
  localparam int CW    = $clog2(SLOTS);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    PRESENT
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic             err_n;
  logic             accept;
  logic             cnt_last;
  logic [SLOTS-1:0] slot_sel;
  logic [SLOTS-1:0] we_a;
  logic [SLOTS-1:0] we_b;

  assign in_ready = reset && (state != PRESENT);
  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt == CW'(SLOTS - 1));
  assign slot_sel = {{(SLOTS-1){1'b0}}, 1'b1} << cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD_A;
      cnt       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out_valid <= (state_n == PRESENT);
      frame_err <= err_n;
    end
  end

  // Offending words are still written; the frame is simply abandoned.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    we_a    = '0;
    we_b    = '0;
    unique case (state)
      LOAD_A: begin
        if (accept) begin
          we_a  = slot_sel;
          cnt_n = cnt + 1'b1;
          if (in_last) begin
            state_n = LOAD_A;
            cnt_n   = '0;
            err_n   = 1'b1;
          end else if (cnt_last) begin
            state_n = LOAD_B;
            cnt_n   = '0;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          we_b  = slot_sel;
          cnt_n = cnt + 1'b1;
          if (cnt_last && in_last) begin
            state_n = PRESENT;
            cnt_n   = '0;
          end else if (cnt_last || in_last) begin
            state_n = LOAD_A;
            cnt_n   = '0;
            err_n   = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_n = LOAD_A;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = LOAD_A;
        cnt_n   = '0;
      end
    endcase
  end

  matrix_slot_writer #(
    .N     (N),
    .SLOTS (SLOTS)
  ) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (we_a),
    .data  (in_data),
    .bus   (a_out)
  );

  matrix_slot_writer #(
    .N     (N),
    .SLOTS (SLOTS)
  ) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (we_b),
    .data  (in_data),
    .bus   (b_out)
  );

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: random and directed
// frames against an in-bench model of the two operand matrices.
module tb_matrix_operand_loader;
  import matrix_operand_loader_pkg::*;

  localparam int W  = COEF_W;
  localparam int S  = MAT_P * MAT_P;
  localparam int BW = S * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [BW-1:0] a_out;
  logic [BW-1:0] b_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          frame_err;

  matrix_operand_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            err;
    int            cyc;
    int            hold;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } exp_t;

  exp_t          sbq[$];
  logic [BW-1:0] ma;
  logic [BW-1:0] mb;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            skip = 1'b1;
  bit            in_pres = 1'b0;
  int            plen = 0;
  exp_t          cur;

  function automatic void chk(input string name,
                              input logic [BW-1:0] act,
                              input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic logic [W-1:0] nom_word(input int k);
    if (k < S) return (k % 5 == 0) ? 32'h0004_0000 : 32'h0;
    return W'(k - S + 1);
  endfunction

  task automatic push(input bit err, input int ac, input int hold);
    exp_t e;
    e.err  = err;
    e.cyc  = ac;
    e.hold = hold;
    e.a    = ma;
    e.b    = mb;
    sbq.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents or flags.
  always @(negedge clk) begin
    cyc++;
    if (skip) begin
      in_pres = 1'b0;
      plen    = 0;
    end else begin
      if (frame_err) begin
        chk("err_vs_valid", out_valid, 0);
        if (sbq.size() == 0) begin
          chk("unexpected_err", 1, 0);
        end else begin
          cur = sbq.pop_front();
          chk("err_kind", cur.err, 1);
          chk("err_latency", cyc, cur.cyc + 1);
        end
      end
      if (out_valid) begin
        chk("present_in_ready", in_ready, 0);
        if (!in_pres) begin
          in_pres = 1'b1;
          plen    = 1;
          if (sbq.size() == 0) begin
            chk("unexpected_valid", 1, 0);
            cur.hold = 0;
          end else begin
            cur = sbq.pop_front();
            chk("valid_kind", cur.err, 0);
            chk("valid_latency", cyc, cur.cyc + 1);
          end
          out_ready = (cur.hold == 0);
        end else begin
          plen++;
          if (plen > cur.hold) out_ready = 1'b1;
        end
        chk("a_out", a_out, cur.a);
        chk("b_out", b_out, cur.b);
      end else if (in_pres) begin
        in_pres = 1'b0;
        chk("present_len", plen, cur.hold + 1);
        chk("ready_after", in_ready, 1);
        out_ready = 1'b1;
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic l,
                           output int ac);
    int t;
    bit acc;
    t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      t++;
      if (t > 400) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    ac = cyc;
  endtask

  // kind: 0 good, 1 in_last at bad_at, 2 no in_last, 3 stop after bad_at
  // gap: fixed idle cycles before each word, or -1 for random
  task automatic send_frame(input int kind, input int bad_at,
                            input int gap, input int hold,
                            input bit nominal);
    logic [W-1:0] d;
    logic         l;
    int           ac;
    int           first;
    int           g;
    bit           stop;
    first = 0;
    stop  = 1'b0;
    for (int k = 0; k < FRAME_LEN && !stop; k++) begin
      d = nominal ? nom_word(k) : W'($urandom);
      l = (kind == 0 && k == FRAME_LEN - 1) || (kind == 1 && k == bad_at);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (g > 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      send_word(d, l, ac);
      if (k < S) ma[k*W +: W] = d;
      else       mb[(k-S)*W +: W] = d;
      if (k == 0) first = ac;
      if (kind == 1 && k == bad_at) begin
        push(1'b1, ac, 0);
        stop = 1'b1;
      end else if (kind == 3 && k == bad_at) begin
        stop = 1'b1;
      end else if (k == FRAME_LEN - 1) begin
        push(kind == 2, ac, hold);
        if (gap == 1) chk("toggle_span", ac - first, 2 * (FRAME_LEN - 1));
      end
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    skip     = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    sbq.delete();
    ma = '0;
    mb = '0;
    @(negedge clk);
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_in_ready_high", in_ready, 1);
    skip = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    int t;
    ma = '0;
    mb = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    send_frame(0, 0, 0, 0, 1);
    send_frame(0, 0, 0, 10, 1);
    send_frame(0, 0, 0, 0, 0);
    send_frame(0, 0, 1, 0, 1);
    send_frame(1, 20, 0, 0, 0);
    send_frame(0, 0, 0, 0, 0);
    send_frame(2, 0, 0, 0, 0);
    send_frame(0, 0, 0, 1, 0);

    send_frame(3, 25, 0, 0, 0);
    do_reset();
    send_frame(0, 0, 0, 2, 0);

    send_frame(0, 0, 0, 20, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("present_seen", out_valid, 1);
    @(posedge clk);
    #1;
    do_reset();
    send_frame(0, 0, 0, 0, 1);

    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      send_frame(1, int'($urandom_range(0, 30)), -1, 0, 0);
      else if (r == 1) send_frame(2, 0, -1, 0, 0);
      else             send_frame(0, 0, -1, int'($urandom_range(0, 3)), 0);
    end

    t = 0;
    while ((sbq.size() > 0 || in_pres) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", sbq.size(), 0);
    chk("drain_present", in_pres, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
